// File: rtl/gc_stream_pkg.sv
// gc_stream_pkg: tag encodings and record types shared by the garbler
// output-stream packer and its FIFO.
package gc_stream_pkg;

  // Garbler tag encodings. A tag with bit 2 set is a label beat and does
  // not appear in this list.
  localparam logic [2:0] TAG_IDLE  = 3'b000;
  localparam logic [2:0] TAG_KEY   = 3'b001;
  localparam logic [2:0] TAG_TABLE = 3'b010;
  localparam logic [2:0] TAG_MASK  = 3'b011;
  localparam int         TAG_LABEL_BIT = 2;

  // Record type carried on out_type.
  typedef enum logic [2:0] {
    REC_KEY   = 3'b001,
    REC_TABLE = 3'b010,
    REC_MASK  = 3'b011,
    REC_LABEL = 3'b100
  } rec_type_e;

endpackage

// File: rtl/gc_stream_packer_if.sv
// gc_stream_packer_if: garbler beat input (tag/index/data lanes plus the
// advisory stall) and the valid/ready record stream towards the host.
// The slave modport is the packer; the master modport is the environment
// that produces beats and consumes records.
interface gc_stream_packer_if #(
  parameter int S = 16,
  parameter int K = 128
);
  logic [2:0]   tag;
  logic [S-1:0] index0;
  logic [S-1:0] index1;
  logic [K-1:0] data0;
  logic [K-1:0] data1;
  logic         stall;

  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_type;
  logic [S-1:0] out_index;
  logic [K-1:0] out_data;

  modport master (
    output tag, index0, index1, data0, data1, out_ready,
    input  stall, out_valid, out_type, out_index, out_data
  );

  modport slave (
    input  tag, index0, index1, data0, data1, out_ready,
    output stall, out_valid, out_type, out_index, out_data
  );
endinterface

// File: rtl/gc_dual_push_fifo.sv
// gc_dual_push_fifo: FIFO accepting up to two entries per cycle (slot
// order wd0 then wd1) and releasing one per cycle. Pointers carry one
// extra wrap bit so occupancy runs 0..DEPTH. Flush has priority over
// any push or pop in the same cycle.
module gc_dual_push_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [W-1:0]             wd0,
  input  logic [W-1:0]             wd1,
  input  logic                     re,
  output logic [W-1:0]             rd,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW:0]   wptr_r;
  logic [AW:0]   rptr_r;
  logic [AW-1:0] addr0_s;
  logic [AW-1:0] addr1_s;
  logic          empty_s;

  // Write slots: lane1 lands directly behind lane0 when both are written.
  always_comb begin
    addr0_s   = wptr_r[AW-1:0];
    addr1_s   = wptr_r[AW-1:0] + {{(AW-1){1'b0}}, we0};
    occupancy = wptr_r - rptr_r;
    empty_s   = (occupancy == {(AW+1){1'b0}});
    rd        = mem_r[rptr_r[AW-1:0]];
  end

  // Storage array; contents need no reset because reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (!flush && we0) begin
      mem_r[addr0_s] <= wd0;
    end
    if (!flush && we1) begin
      mem_r[addr1_s] <= wd1;
    end
  end

  // Read/write pointers with synchronous reset and flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      wptr_r <= wptr_r + {{AW{1'b0}}, we0} + {{AW{1'b0}}, we1};
      if (re && !empty_s) begin
        rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end
endmodule

// File: rtl/gc_stream_packer.sv
// gc_stream_packer: decodes each garbler beat into 0-2 typed records,
// queues them in a dual-push FIFO and drains one per cycle to the host.
// A beat is stored whole or not at all; a beat that does not fit is
// dropped and flagged. After the mask record is stored the stream is
// closed and further beats are ignored until start.
module gc_stream_packer
  import gc_stream_pkg::*;
#(
  parameter int S     = 16,
  parameter int K     = 128,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  gc_stream_packer_if.slave bus,
  output logic [S:0]        n_labels,
  output logic [S:0]        n_tables,
  output logic              overflow,
  output logic              done
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] TWO_C   = (AW+1)'(2);

  typedef struct packed {
    rec_type_e    rtype;
    logic [S-1:0] index;
    logic [K-1:0] data;
  } record_t;

  record_t      rec0_s;
  record_t      rec1_s;
  record_t      head_s;
  logic [1:0]   n_rec_s;
  logic [1:0]   lbl_inc_s;
  logic [1:0]   tbl_inc_s;
  logic         mask_beat_s;
  logic         active_s;
  logic         fits_s;
  logic         push_s;
  logic         drop_s;
  logic         pop_s;
  logic         valid_s;
  logic         we1_s;
  logic [AW:0]  occ_s;
  logic [AW:0]  free_s;
  logic [AW:0]  occ_next_s;
  logic [AW:0]  free_next_s;
  logic [S+1:0] lbl_sum_s;
  logic [S+1:0] tbl_sum_s;
  logic [S:0]   lbl_next_s;
  logic [S:0]   tbl_next_s;

  logic         closed_r;
  logic         stall_r;
  logic         overflow_r;
  logic         done_r;
  logic [S:0]   n_labels_r;
  logic [S:0]   n_tables_r;

  // Tag decode: lane0 record always goes to slot 0, so a lane1-only label
  // beat is steered into slot 0.
  always_comb begin
    rec0_s.rtype = REC_KEY;
    rec0_s.index = {S{1'b0}};
    rec0_s.data  = {K{1'b0}};
    rec1_s.rtype = REC_KEY;
    rec1_s.index = {S{1'b0}};
    rec1_s.data  = {K{1'b0}};
    n_rec_s      = 2'd0;
    lbl_inc_s    = 2'd0;
    tbl_inc_s    = 2'd0;
    mask_beat_s  = 1'b0;
    if (bus.tag[TAG_LABEL_BIT]) begin
      rec0_s.rtype = REC_LABEL;
      rec1_s.rtype = REC_LABEL;
      if (bus.tag[0] && bus.tag[1]) begin
        rec0_s.index = bus.index0;
        rec0_s.data  = bus.data0;
        rec1_s.index = bus.index1;
        rec1_s.data  = bus.data1;
        n_rec_s      = 2'd2;
      end else if (bus.tag[0]) begin
        rec0_s.index = bus.index0;
        rec0_s.data  = bus.data0;
        n_rec_s      = 2'd1;
      end else if (bus.tag[1]) begin
        rec0_s.index = bus.index1;
        rec0_s.data  = bus.data1;
        n_rec_s      = 2'd1;
      end else begin
        n_rec_s      = 2'd0;
      end
      lbl_inc_s = n_rec_s;
    end else begin
      case (bus.tag)
        TAG_IDLE: begin
          n_rec_s = 2'd0;
        end
        TAG_KEY: begin
          rec0_s.rtype = REC_KEY;
          rec0_s.index = {S{1'b0}};
          rec0_s.data  = bus.data0;
          rec1_s.rtype = REC_KEY;
          rec1_s.index = {{(S-1){1'b0}}, 1'b1};
          rec1_s.data  = bus.data1;
          n_rec_s      = 2'd2;
        end
        TAG_TABLE: begin
          rec0_s.rtype = REC_TABLE;
          rec0_s.index = bus.index0;
          rec0_s.data  = bus.data0;
          rec1_s.rtype = REC_TABLE;
          rec1_s.index = bus.index1;
          rec1_s.data  = bus.data1;
          n_rec_s      = 2'd2;
          tbl_inc_s    = 2'd2;
        end
        TAG_MASK: begin
          rec0_s.rtype = REC_MASK;
          rec0_s.index = {S{1'b0}};
          rec0_s.data  = bus.data0;
          n_rec_s      = 2'd1;
          mask_beat_s  = 1'b1;
        end
        default: begin
          n_rec_s = 2'd0;
        end
      endcase
    end
  end

  // Admission and occupancy bookkeeping; the fit check uses occupancy
  // before this cycle's pop, so it never relies on the consumer.
  always_comb begin
    valid_s     = (occ_s != {(AW+1){1'b0}});
    free_s      = DEPTH_C - occ_s;
    active_s    = !start && !closed_r && (n_rec_s != 2'd0);
    fits_s      = (free_s >= {{(AW-1){1'b0}}, n_rec_s});
    push_s      = active_s && fits_s;
    drop_s      = active_s && !fits_s;
    we1_s       = push_s && (n_rec_s == 2'd2);
    pop_s       = valid_s && bus.out_ready && !start;
    occ_next_s  = occ_s
                + (push_s ? {{(AW-1){1'b0}}, n_rec_s} : {(AW+1){1'b0}})
                - {{AW{1'b0}}, pop_s};
    free_next_s = DEPTH_C - occ_next_s;
  end

  // Saturating counter next values.
  always_comb begin
    lbl_sum_s = {1'b0, n_labels_r} + {{S{1'b0}}, lbl_inc_s};
    tbl_sum_s = {1'b0, n_tables_r} + {{S{1'b0}}, tbl_inc_s};
    if (lbl_sum_s[S+1]) begin
      lbl_next_s = {(S+1){1'b1}};
    end else begin
      lbl_next_s = lbl_sum_s[S:0];
    end
    if (tbl_sum_s[S+1]) begin
      tbl_next_s = {(S+1){1'b1}};
    end else begin
      tbl_next_s = tbl_sum_s[S:0];
    end
  end

  gc_dual_push_fifo #(
    .W     ($bits(record_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start),
    .we0       (push_s),
    .we1       (we1_s),
    .wd0       (rec0_s),
    .wd1       (rec1_s),
    .re        (pop_s),
    .rd        (head_s),
    .occupancy (occ_s)
  );

  // Status flags, counters and stall; start clears everything like reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      closed_r   <= 1'b0;
      stall_r    <= 1'b0;
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
      n_labels_r <= {(S+1){1'b0}};
      n_tables_r <= {(S+1){1'b0}};
    end else if (start) begin
      closed_r   <= 1'b0;
      stall_r    <= 1'b0;
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
      n_labels_r <= {(S+1){1'b0}};
      n_tables_r <= {(S+1){1'b0}};
    end else begin
      stall_r <= (free_next_s < TWO_C);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (push_s && mask_beat_s) begin
        closed_r <= 1'b1;
      end
      if (pop_s && (head_s.rtype == REC_MASK)) begin
        done_r <= 1'b1;
      end
      if (push_s) begin
        n_labels_r <= lbl_next_s;
        n_tables_r <= tbl_next_s;
      end
    end
  end

  // Output drive: record fields read as zero while the FIFO is empty.
  always_comb begin
    bus.stall     = stall_r;
    bus.out_valid = valid_s;
    if (valid_s) begin
      bus.out_type  = head_s.rtype;
      bus.out_index = head_s.index;
      bus.out_data  = head_s.data;
    end else begin
      bus.out_type  = 3'b000;
      bus.out_index = {S{1'b0}};
      bus.out_data  = {K{1'b0}};
    end
    n_labels = n_labels_r;
    n_tables = n_tables_r;
    overflow = overflow_r;
    done     = done_r;
  end
endmodule

// File: tb/tb_gc_stream_packer.sv
// tb_gc_stream_packer: directed scenarios followed by randomized beats.
// A queue-based reference model predicts the record stream and status;
// a separate monitor compares DUT outputs each falling edge.
module tb_gc_stream_packer;
  localparam int S     = 16;
  localparam int K     = 128;
  localparam int DEPTH = 16;

  typedef struct {
    logic [2:0]   t;
    logic [S-1:0] idx;
    logic [K-1:0] d;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [S:0] n_labels;
  logic [S:0] n_tables;
  logic       overflow;
  logic       done;

  gc_stream_packer_if #(.S(S), .K(K)) bus ();

  gc_stream_packer #(.S(S), .K(K), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .n_labels (n_labels),
    .n_tables (n_tables),
    .overflow (overflow),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Model state: m_* is what the DUT should hold after the coming edge,
  // cur_* what it should hold now.
  rec_t       exp_q[$];
  logic [S:0] m_lbl = '0, m_tbl = '0, cur_lbl = '0, cur_tbl = '0;
  logic       m_ovf = 1'b0, m_done = 1'b0, m_stall = 1'b0, m_closed = 1'b0;
  logic       cur_ovf = 1'b0, cur_done = 1'b0, cur_stall = 1'b0;
  int         cur_occ = 0;
  bit         mon_en = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [2:0] t, input logic [S-1:0] i, input logic [K-1:0] d);
    rec_t r;
    r.t = t;
    r.idx = i;
    r.d = d;
    return r;
  endfunction

  function automatic logic [S:0] sat_add(input logic [S:0] a, input int n);
    int s;
    s = int'(a) + n;
    if (s > (1 << (S + 1)) - 1) return {(S+1){1'b1}};
    return (S+1)'(s);
  endfunction

  function automatic logic [K-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock cycle of stimulus plus the model update for the coming edge.
  task automatic cycle(input logic rst, input logic st, input logic [2:0] t,
                       input logic [S-1:0] i0, input logic [S-1:0] i1,
                       input logic [K-1:0] d0, input logic [K-1:0] d1,
                       input logic rdy);
    rec_t recs[$];
    int   pre;
    int   pushed;
    int   popn;
    @(posedge clk);
    #1;
    cur_occ   = exp_q.size();
    cur_lbl   = m_lbl;
    cur_tbl   = m_tbl;
    cur_ovf   = m_ovf;
    cur_done  = m_done;
    cur_stall = m_stall;
    rst_n         = !rst;
    start         = st;
    bus.tag       = t;
    bus.index0    = i0;
    bus.index1    = i1;
    bus.data0     = d0;
    bus.data1     = d1;
    bus.out_ready = rdy;
    pre = exp_q.size();
    pushed = 0;
    if (rst || st) begin
      exp_q.delete();
      m_lbl = '0; m_tbl = '0; m_ovf = 1'b0; m_done = 1'b0;
      m_stall = 1'b0; m_closed = 1'b0;
    end else begin
      popn = (rdy && pre > 0) ? 1 : 0;
      if (popn == 1 && exp_q[0].t == 3'b011) m_done = 1'b1;
      if (t[2]) begin
        if (t[0]) recs.push_back(mk(3'b100, i0, d0));
        if (t[1]) recs.push_back(mk(3'b100, i1, d1));
      end else if (t == 3'b001) begin
        recs.push_back(mk(3'b001, 16'd0, d0));
        recs.push_back(mk(3'b001, 16'd1, d1));
      end else if (t == 3'b010) begin
        recs.push_back(mk(3'b010, i0, d0));
        recs.push_back(mk(3'b010, i1, d1));
      end else if (t == 3'b011) begin
        recs.push_back(mk(3'b011, 16'd0, d0));
      end
      if (!m_closed && recs.size() > 0) begin
        if (DEPTH - pre >= recs.size()) begin
          foreach (recs[k]) begin
            exp_q.push_back(recs[k]);
            if (recs[k].t == 3'b100) m_lbl = sat_add(m_lbl, 1);
            if (recs[k].t == 3'b010) m_tbl = sat_add(m_tbl, 1);
          end
          pushed = recs.size();
          if (t == 3'b011) m_closed = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_stall = (DEPTH - (pre - popn + pushed)) < 2;
    end
  endtask

  task automatic beat(input logic [2:0] t, input logic [S-1:0] i0, input logic [S-1:0] i1,
                      input logic rdy);
    cycle(1'b0, 1'b0, t, i0, i1, rnd_data(), rnd_data(), rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int c = 0; c < n; c++) cycle(1'b0, 1'b0, 3'b000, '0, '0, '0, '0, rdy);
  endtask

  // Monitor: status checks every cycle, record check on each handshake.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("out_valid", K'(bus.out_valid), K'(cur_occ != 0));
        chk("stall",     K'(bus.stall),     K'(cur_stall));
        chk("n_labels",  K'(n_labels),      K'(cur_lbl));
        chk("n_tables",  K'(n_tables),      K'(cur_tbl));
        chk("overflow",  K'(overflow),      K'(cur_ovf));
        chk("done",      K'(done),          K'(cur_done));
        if (cur_occ == 0) begin
          chk("idle_type",  K'(bus.out_type),  '0);
          chk("idle_index", K'(bus.out_index), '0);
          chk("idle_data",  bus.out_data,      '0);
        end
        if (bus.out_valid && bus.out_ready && !start && rst_n) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_record", K'(1), K'(0));
          end else begin
            e = exp_q.pop_front();
            chk("rec_type",  K'(bus.out_type),  K'(e.t));
            chk("rec_index", K'(bus.out_index), K'(e.idx));
            chk("rec_data",  bus.out_data,      e.d);
          end
        end
      end
    end
  end

  initial begin
    bus.tag = 3'b000; bus.index0 = '0; bus.index1 = '0;
    bus.data0 = '0; bus.data1 = '0; bus.out_ready = 1'b0;

    // Reset with random inputs on the beat lanes.
    for (int c = 0; c < 2; c++)
      cycle(1'b1, 1'b0, 3'($urandom_range(0, 7)), 16'($urandom()), 16'($urandom()),
            rnd_data(), rnd_data(), 1'($urandom_range(0, 1)));
    mon_en = 1'b1;
    idle(1, 1'b0);

    // Label beats: records 3, 7, 8, 9.
    beat(3'b101, 16'd3, 16'd99, 1'b1);
    beat(3'b110, 16'd98, 16'd7, 1'b1);
    beat(3'b111, 16'd8, 16'd9, 1'b1);
    idle(6, 1'b1);

    // Keys then tables with the consumer stalled; last table beat overflows.
    cycle(1'b0, 1'b1, 3'b000, '0, '0, '0, '0, 1'b0);
    beat(3'b001, 16'd0, 16'd0, 1'b0);
    for (int b = 0; b < 8; b++) beat(3'b010, 16'(2 * b), 16'(2 * b + 1), 1'b0);
    idle(2, 1'b0);
    idle(18, 1'b1);

    // Mask closes the stream; a later label beat is ignored.
    cycle(1'b0, 1'b0, 3'b011, '0, '0, 128'hA5, rnd_data(), 1'b1);
    idle(3, 1'b1);
    beat(3'b101, 16'd5, 16'd6, 1'b1);
    idle(3, 1'b1);

    // FIFO at DEPTH-1 with a pop: a two-record beat is still refused.
    cycle(1'b0, 1'b1, 3'b000, '0, '0, '0, '0, 1'b0);
    for (int b = 0; b < 7; b++) beat(3'b001, '0, '0, 1'b0);
    beat(3'b101, 16'd44, 16'd0, 1'b0);
    beat(3'b010, 16'd50, 16'd51, 1'b1);
    idle(18, 1'b1);

    // Start coinciding with a table beat while records are queued.
    beat(3'b001, '0, '0, 1'b0);
    beat(3'b001, '0, '0, 1'b0);
    cycle(1'b0, 1'b1, 3'b010, 16'd1, 16'd2, rnd_data(), rnd_data(), 1'b1);
    idle(3, 1'b1);

    // Randomized traffic with occasional start and reset.
    for (int c = 0; c < 1500; c++) begin
      cycle(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 29) == 0),
            3'($urandom_range(0, 7)), 16'($urandom()), 16'($urandom()),
            rnd_data(), rnd_data(), 1'($urandom_range(0, 3) != 0));
    end
    idle(DEPTH + 4, 1'b1);
    @(negedge clk);
    #1;
    chk("drained", K'(exp_q.size()), K'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
